mode_finder_unit: RTL and testbench
===================================

Name: mode_finder_unit

Overview:
- Hardware accelerator that computes the statistical mode (most frequent value) of a variable-length dataset, replacing the software nested-loop mode routine on the MIPS32 core.
- Accepts a stream of DATA_W-bit samples over a valid/ready handshake and buffers up to DEPTH samples.
- Runs a one-compare-per-cycle nested scan, then presents the mode value and its frequency on a valid/ready result port.
- Sits beside the core as a memory-mapped or streaming coprocessor.

Parameters:
- DATA_W, 32, sample width in bits.
- DEPTH, 8, maximum samples per dataset (must be >= 1).
- CNT_W, $clog2(DEPTH+1), width of the count and frequency fields (derived; not overridden).

Ports:
- clk1  in  1  single system clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample present.
- in_ready  out  1  unit can accept a sample.
- in_data  in  DATA_W  sample value, unsigned compare (equality only).
- in_last  in  1  marks the final sample of the dataset.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_mode  out  DATA_W  mode value.
- out_freq  out  CNT_W  occurrence count of out_mode.
- out_len  out  CNT_W  number of samples in the dataset.
- busy  out  1  high in SCAN.

Behaviour:
- Reset: state=LOAD; in_ready=1; out_valid=0; out_mode=0; out_freq=0; out_len=0; busy=0; all indices and counts cleared. Reset mid-LOAD or mid-SCAN discards the dataset. The buffer contents need no clearing.
- LOAD:
  - Each cycle with in_valid&&in_ready writes buf[n]=in_data and increments n.
  - Leave for SCAN on the accepting edge when in_last=1 or when the accepted sample is the DEPTH-th; in_last is then implied.
  - in_ready is 0 outside LOAD.
  - An empty dataset is impossible: LOAD only exits on an accepted sample.
- SCAN:
  - Index i runs 0..n-1 (outer); index j runs 0..n-1 (inner). One compare buf[i]==buf[j] per cycle.
  - cnt accumulates matches for the current i.
  - On j==n-1, let total = cnt + current match. If total > max_freq (strict), then max_freq=total and mode=buf[i].
  - Then cnt=0, j=0, i++.
  - Ties resolve to the earliest-index value.
  - Scan length is exactly n*n cycles. After the i==n-1, j==n-1 cycle the unit enters DONE.
- DONE:
  - out_valid=1; out_mode, out_freq and out_len are stable while out_valid && !out_ready.
  - On out_valid&&out_ready the unit returns to LOAD on the next cycle with n, i, j, max_freq and mode cleared. in_ready=1 from that cycle.
- Latency: out_valid rises n*n+1 cycles after the final input handshake edge. With DEPTH=8 and full data, that is 65 cycles.
- Width rules: counts saturate-free, because n<=DEPTH fits in CNT_W. Comparisons are bitwise equality only.
- Simultaneous events: rst dominates everything. in_valid during SCAN or DONE is ignored and not accepted.

Optional Feature:
- Macro: MODE_FINDER_EARLY_EXIT_EN.
- When defined: at each outer-iteration boundary, if max_freq >= n-i (remaining candidates cannot strictly exceed it), SCAN terminates immediately to DONE.
  - Results are identical to the full scan.
  - Latency becomes data-dependent, never more than n*n+1.
- When undefined: the scan always lasts exactly n*n cycles.

Decomposition:
- Package mode_finder_pkg: state enum {LOAD, SCAN, DONE}, and a CNT_W helper function (clog2-based).
- One natural sub-module, mode_buf: DEPTH x DATA_W register array with one write port and two combinational read ports (i and j).
- The FSM, counters and compare live in the top.

Test Plan:
- Stream 1,2,3,4,8,6,7,8 (last on the 8th) -> out_mode=8, out_freq=2, out_len=8; out_valid exactly 65 cycles after the last handshake (feature off).
- Stream 5,9,5,9,3 with last -> tie resolves to first: out_mode=5, out_freq=2, out_len=5.
- Stream 8 distinct values without in_last -> load stops at DEPTH; in_ready=0 on the next cycle; out_mode=first value, out_freq=1.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then assert out_ready -> next dataset 7 (single, last) yields mode=7, freq=1, len=1 after 2 cycles.
- Assert rst for 1 cycle mid-SCAN -> busy=0 and in_ready=1 the next cycle, no out_valid. A new dataset 4,4,4 gives mode=4, freq=3.
- With MODE_FINDER_EARLY_EXIT_EN, dataset 6,6,6,6,6,1,2,3 -> mode=6, freq=5, out_valid well before 65 cycles (at i=3 boundary: 5>=5).

Source files
------------

// File: rtl/mode_finder_pkg.sv
// Shared types and width helpers for the mode finder.
package mode_finder_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count fields must hold the value DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mode_finder_if.sv
// Sample stream in, result out. Handshake: a transfer happens on the rising
// clk1 edge where valid && ready; the source holds data steady while valid && !ready.
interface mode_finder_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = mode_finder_pkg::cnt_width(DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mode;
  logic [CNT_W-1:0]  out_freq;
  logic [CNT_W-1:0]  out_len;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_mode, out_freq, out_len
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_mode, out_freq, out_len
  );
endinterface

// File: rtl/mode_finder_unit_buf.sv
// Dataset storage: one write port, two combinational read ports (row and column index).
module mode_buf
  import mode_finder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk1,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  row_addr,
  input  logic [IDX_W-1:0]  col_addr,
  output logic [DATA_W-1:0] row_data,
  output logic [DATA_W-1:0] col_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk1) begin
    if (we) mem[waddr] <= wdata;
  end

  assign row_data = mem[row_addr];
  assign col_data = mem[col_addr];
endmodule

// File: rtl/mode_finder_unit.sv
// Mode finder: buffers a dataset, runs an n*n compare scan, reports mode/frequency/length.
// Optional MODE_FINDER_EARLY_EXIT_EN stops the scan once no later row can beat the current best.
module mode_finder_unit
  import mode_finder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic          clk1,
  input  logic          rst,
  mode_finder_if.slave  bus,
  output logic          busy,
  output state_t        dbg_state
);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = idx_width(DEPTH);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  n, i, j, cnt, max_freq, total;
  logic [DATA_W-1:0] mode, row_data, col_data;
  logic              out_valid_q;
  logic              accept, match, row_end, last_row, early_stop, scan_end;

  assign accept   = (state == LOAD) && bus.in_valid;
  assign match    = (row_data == col_data);
  assign row_end  = (j == n - CNT_W'(1));
  assign last_row = (i == n - CNT_W'(1));
  assign total    = cnt + CNT_W'(match);

`ifdef MODE_FINDER_EARLY_EXIT_EN
  logic [CNT_W-1:0] best, remaining;
  // Rows after i can reach at most n-i-1 matches; a strict improvement is then impossible.
  assign best       = (total > max_freq) ? total : max_freq;
  assign remaining  = n - i - CNT_W'(1);
  assign early_stop = (best >= remaining);
`else
  assign early_stop = 1'b0;
`endif

  assign scan_end = row_end && (last_row || early_stop);

  always_ff @(posedge clk1) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (accept && (bus.in_last || n == CNT_W'(DEPTH - 1))) state_nx = SCAN;
      SCAN: if (scan_end) state_nx = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      n           <= '0;
      i           <= '0;
      j           <= '0;
      cnt         <= '0;
      max_freq    <= '0;
      mode        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        LOAD: if (accept) n <= n + CNT_W'(1);
        SCAN: begin
          if (row_end) begin
            cnt <= '0;
            j   <= '0;
            i   <= i + CNT_W'(1);
            if (total > max_freq) begin
              max_freq <= total;
              mode     <= row_data;
            end
          end else begin
            cnt <= total;
            j   <= j + CNT_W'(1);
          end
        end
        DONE: begin
          // Result is presented one cycle after entering DONE.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            n           <= '0;
            i           <= '0;
            j           <= '0;
            cnt         <= '0;
            max_freq    <= '0;
            mode        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  mode_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk1    (clk1),
    .we      (accept),
    .waddr   (n[IDX_W-1:0]),
    .wdata   (bus.in_data),
    .row_addr(i[IDX_W-1:0]),
    .col_addr(j[IDX_W-1:0]),
    .row_data(row_data),
    .col_data(col_data)
  );

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_mode  = mode;
  assign bus.out_freq  = max_freq;
  assign bus.out_len   = n;
  assign busy          = (state == SCAN);
  assign dbg_state     = state;
endmodule

// File: tb/tb_mode_finder_unit.sv
// Bench for mode_finder_unit: directed scenarios plus randomized datasets against a counting model.
module tb_mode_finder_unit;
  import mode_finder_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = cnt_width(DEPTH);

  typedef logic [DATA_W-1:0] word_t;

  logic   clk1 = 1'b0;
  logic   rst  = 1'b1;
  logic   busy;
  state_t dbg_state;

  mode_finder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

  mode_finder_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk1     (clk1),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int last_hs     = 0;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Mode = most frequent value; ties go to the value appearing first in the stream.
  function automatic void model(input word_t vals[$], output word_t m, output int f);
    int counts[word_t];
    m = '0;
    f = 0;
    foreach (vals[k]) counts[vals[k]] = counts.exists(vals[k]) ? counts[vals[k]] + 1 : 1;
    foreach (vals[k]) begin
      if (counts[vals[k]] > f) begin
        f = counts[vals[k]];
        m = vals[k];
      end
    end
  endfunction

  task automatic load_dataset(input word_t vals[$], input bit use_last, input bit gaps);
    for (int k = 0; k < vals.size(); k++) begin
      int w;
      if (gaps) repeat ($urandom_range(0, 1)) step();
      bus.in_valid = 1'b1;
      bus.in_data  = vals[k];
      bus.in_last  = use_last && (k == vals.size() - 1);
      w = 0;
      while (!bus.in_ready && w < 200) begin
        step();
        w++;
      end
      if (!bus.in_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL load_timeout in_ready=%0b required 1", bus.in_ready);
      end
      step();
      last_hs = cyc;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic wait_result(output int lat);
    int w = 0;
    while (!bus.out_valid && w < 300) begin
      step();
      w++;
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL result_timeout out_valid=%0b required 1", bus.out_valid);
    end
    lat = cyc - last_hs;
  endtask

  task automatic accept_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    vectors += 6;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    if (bus.out_mode !== '0) begin miscompares++; $display("FAIL reset_out_mode got %0d exp 0", bus.out_mode); end
    if (bus.out_freq !== '0) begin miscompares++; $display("FAIL reset_out_freq got %0d exp 0", bus.out_freq); end
    if (bus.out_len !== '0) begin miscompares++; $display("FAIL reset_out_len got %0d exp 0", bus.out_len); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy); end
  endtask

  task automatic test_basic_mode();
    word_t q[$];
    int lat;
    q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd6, 32'd7, 32'd8};
    load_dataset(q, 1'b1, 1'b0);
    wait_result(lat);
    vectors += 4;
    if (bus.out_mode !== 32'd8) begin miscompares++; $display("FAIL basic_mode got %0d exp 8", bus.out_mode); end
    if (bus.out_freq !== CNT_W'(2)) begin miscompares++; $display("FAIL basic_freq got %0d exp 2", bus.out_freq); end
    if (bus.out_len !== CNT_W'(8)) begin miscompares++; $display("FAIL basic_len got %0d exp 8", bus.out_len); end
`ifdef MODE_FINDER_EARLY_EXIT_EN
    if (lat > 65) begin miscompares++; $display("FAIL basic_latency got %0d exp <=65", lat); end
`else
    if (lat != 65) begin miscompares++; $display("FAIL basic_latency got %0d exp 65", lat); end
`endif
    accept_result();
  endtask

  task automatic test_tie();
    word_t q[$];
    int lat;
    q = '{32'd5, 32'd9, 32'd5, 32'd9, 32'd3};
    load_dataset(q, 1'b1, 1'b1);
    wait_result(lat);
    vectors += 3;
    if (bus.out_mode !== 32'd5) begin miscompares++; $display("FAIL tie_mode got %0d exp 5", bus.out_mode); end
    if (bus.out_freq !== CNT_W'(2)) begin miscompares++; $display("FAIL tie_freq got %0d exp 2", bus.out_freq); end
    if (bus.out_len !== CNT_W'(5)) begin miscompares++; $display("FAIL tie_len got %0d exp 5", bus.out_len); end
    accept_result();
  endtask

  task automatic test_depth_limit();
    word_t q[$];
    word_t base;
    int lat;
    base = word_t'($urandom_range(100, 1000));
    for (int k = 0; k < DEPTH; k++) q.push_back(base + word_t'(k * 3));
    load_dataset(q, 1'b0, 1'b0);
    vectors += 2;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL depth_in_ready got %0b exp 0", bus.in_ready); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL depth_busy got %0b exp 1", busy); end
    wait_result(lat);
    vectors += 3;
    if (bus.out_mode !== base) begin miscompares++; $display("FAIL depth_mode got %0d exp %0d", bus.out_mode, base); end
    if (bus.out_freq !== CNT_W'(1)) begin miscompares++; $display("FAIL depth_freq got %0d exp 1", bus.out_freq); end
    if (bus.out_len !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL depth_len got %0d exp %0d", bus.out_len, DEPTH); end
    accept_result();
  endtask

  task automatic test_hold_done();
    word_t q[$];
    word_t m;
    int f, lat;
    q = '{32'd3, 32'd1, 32'd3};
    model(q, m, f);
    load_dataset(q, 1'b1, 1'b0);
    wait_result(lat);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = word_t'($urandom);
      step();
      vectors += 4;
      if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid cyc %0d got %0b exp 1", c, bus.out_valid); end
      if (bus.out_mode !== m) begin miscompares++; $display("FAIL hold_mode cyc %0d got %0d exp %0d", c, bus.out_mode, m); end
      if (bus.out_freq !== CNT_W'(f)) begin miscompares++; $display("FAIL hold_freq cyc %0d got %0d exp %0d", c, bus.out_freq, f); end
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready cyc %0d got %0b exp 0", c, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    accept_result();
    vectors += 3;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %0b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL release_out_valid got %0b exp 0", bus.out_valid); end
    if (bus.out_len !== '0) begin miscompares++; $display("FAIL release_len got %0d exp 0", bus.out_len); end
    q = '{32'd7};
    load_dataset(q, 1'b1, 1'b0);
    wait_result(lat);
    vectors += 4;
    if (lat != 2) begin miscompares++; $display("FAIL single_latency got %0d exp 2", lat); end
    if (bus.out_mode !== 32'd7) begin miscompares++; $display("FAIL single_mode got %0d exp 7", bus.out_mode); end
    if (bus.out_freq !== CNT_W'(1)) begin miscompares++; $display("FAIL single_freq got %0d exp 1", bus.out_freq); end
    if (bus.out_len !== CNT_W'(1)) begin miscompares++; $display("FAIL single_len got %0d exp 1", bus.out_len); end
    accept_result();
  endtask

  task automatic test_reset_mid_scan();
    word_t q[$];
    int lat;
    bit seen;
    q = '{32'd1, 32'd2, 32'd3};
    load_dataset(q, 1'b1, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors += 3;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %0b exp 0", busy); end
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %0b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %0b exp 0", bus.out_valid); end
    seen = 1'b0;
    repeat (15) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL midrst_spurious_valid got 1 exp 0"); end
    q = '{32'd4, 32'd4, 32'd4};
    load_dataset(q, 1'b1, 1'b0);
    wait_result(lat);
    vectors += 3;
    if (bus.out_mode !== 32'd4) begin miscompares++; $display("FAIL midrst_mode got %0d exp 4", bus.out_mode); end
    if (bus.out_freq !== CNT_W'(3)) begin miscompares++; $display("FAIL midrst_freq got %0d exp 3", bus.out_freq); end
    if (bus.out_len !== CNT_W'(3)) begin miscompares++; $display("FAIL midrst_len got %0d exp 3", bus.out_len); end
    accept_result();
  endtask

  task automatic test_early_exit();
    word_t q[$];
    int lat;
    q = '{32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd1, 32'd2, 32'd3};
    load_dataset(q, 1'b1, 1'b0);
    wait_result(lat);
    vectors += 3;
    if (bus.out_mode !== 32'd6) begin miscompares++; $display("FAIL early_mode got %0d exp 6", bus.out_mode); end
    if (bus.out_freq !== CNT_W'(5)) begin miscompares++; $display("FAIL early_freq got %0d exp 5", bus.out_freq); end
`ifdef MODE_FINDER_EARLY_EXIT_EN
    if (lat != 25) begin miscompares++; $display("FAIL early_latency got %0d exp 25", lat); end
`else
    if (lat != 65) begin miscompares++; $display("FAIL early_latency got %0d exp 65", lat); end
`endif
    accept_result();
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      word_t q[$];
      word_t m;
      int f, len, lat;
      bit use_last, wide;
      len      = $urandom_range(1, DEPTH);
      use_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      wide     = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < len; k++)
        q.push_back(wide ? word_t'($urandom) : word_t'($urandom_range(0, 3)));
      model(q, m, f);
      load_dataset(q, use_last, 1'b1);
      wait_result(lat);
      vectors += 4;
      if (bus.out_mode !== m) begin miscompares++; $display("FAIL rand%0d_mode got %0d exp %0d", t, bus.out_mode, m); end
      if (bus.out_freq !== CNT_W'(f)) begin miscompares++; $display("FAIL rand%0d_freq got %0d exp %0d", t, bus.out_freq, f); end
      if (bus.out_len !== CNT_W'(len)) begin miscompares++; $display("FAIL rand%0d_len got %0d exp %0d", t, bus.out_len, len); end
`ifdef MODE_FINDER_EARLY_EXIT_EN
      if (lat > len * len + 1) begin miscompares++; $display("FAIL rand%0d_latency got %0d exp <=%0d", t, lat, len * len + 1); end
`else
      if (lat != len * len + 1) begin miscompares++; $display("FAIL rand%0d_latency got %0d exp %0d", t, lat, len * len + 1); end
`endif
      repeat ($urandom_range(0, 3)) step();
      accept_result();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_mode();
    test_tie();
    test_depth_limit();
    test_hold_done();
    test_reset_mid_scan();
    test_early_exit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
